// File: rtl/max_sched_pkg.sv
// max_sched_pkg: shared types and constants for the max_sched scheduler.
package max_sched_pkg;

  // Lanes per word and pipeline depth of max_finder.
  localparam int NUM_LANES = 4;
  localparam int PIPE_LAT  = 2;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Requester identifier (two requesters).
  typedef logic req_id_t;

endpackage

// File: rtl/max_finder.sv
// max_finder: two-stage four-lane unsigned max pipeline.
// Stage 1 reduces lane pairs, stage 2 reduces the pair maxima.
// Data flows every cycle; the caller tracks which outputs are meaningful.
module max_finder
  import max_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]  lanes_i,
  output logic [WIDTH-1:0]                 max_o
);

  localparam int PAIRS = NUM_LANES / 2;

  logic [PAIRS-1:0][WIDTH-1:0] pair_d, pair_q;
  logic [WIDTH-1:0]            max_d, max_q;

  // Pairwise reduction of adjacent lanes.
  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    assign pair_d[p] = (lanes_i[2*p] > lanes_i[2*p+1]) ? lanes_i[2*p] : lanes_i[2*p+1];
  end

  assign max_d = (pair_q[0] > pair_q[1]) ? pair_q[0] : pair_q[1];

  // Pipeline registers, cleared on reset so no stale data survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_q <= '0;
      max_q  <= '0;
    end else begin
      pair_q <= pair_d;
      max_q  <= max_d;
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/max_sched.sv
// max_sched: round-robin scheduler sharing one max_finder pipeline between
// two burst requesters; returns one tagged per-burst maximum over valid/ready.
// Optional watchdog: define MAX_SCHED_TIMEOUT_EN to force-close bursts whose
// owner stalls for TIMEOUT cycles (res_timeout flags those results).
module max_sched
  import max_sched_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [NUM_LANES*WIDTH-1:0] req0_lanes,
  input  logic                       req0_last,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [NUM_LANES*WIDTH-1:0] req1_lanes,
  input  logic                       req1_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_value,
  output logic                       res_id,
  output logic [CNT_W-1:0]           res_count,
  output logic                       res_timeout
);

  state_e                         state_q;
  req_id_t                        grant_q, ptr_q, win;
  logic [1:0]                     rdy_q;
  logic                           res_valid_q;
  logic [WIDTH-1:0]               acc_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [PIPE_LAT-1:0]            vld_pipe_q;
  logic [NUM_LANES-1:0][WIDTH-1:0] mux_lanes;
  logic [WIDTH-1:0]               pipe_max;
  logic                           sel_last, accept, drain_empty, res_hs, stall_hit;

  // Input mux follows the registered grant, so the pipeline only sees the owner.
  assign mux_lanes = grant_q ? req1_lanes : req0_lanes;
  assign sel_last  = grant_q ? req1_last  : req0_last;

  // rdy_q only ever has the owner's bit set, and only in ACTIVE.
  assign accept = |(rdy_q & {req1_valid, req0_valid});
  assign res_hs = res_valid_q & res_ready;

  // Pipeline is empty next cycle once nothing sits ahead of the tail stage.
  assign drain_empty = ~|vld_pipe_q[PIPE_LAT-2:0];

  // Winner on contention is the pointer; otherwise whoever is requesting.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) win = ptr_q;
    else if (req1_valid)          win = 1'b1;
  end

  max_finder #(.WIDTH(WIDTH)) u_max_finder (
    .clk     (clk),
    .reset   (reset),
    .lanes_i (mux_lanes),
    .max_o   (pipe_max)
  );

`ifdef MAX_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic               sel_valid;
  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign stall_hit = (state_q == ACTIVE) && !sel_valid &&
                     (stall_q == STALL_W'(TIMEOUT - 1));

  // Stall counter: counts owner-idle cycles in ACTIVE, cleared by any accept.
  always_ff @(posedge clk) begin
    if (reset)                              stall_q <= '0;
    else if (state_q != ACTIVE || accept)   stall_q <= '0;
    else                                    stall_q <= stall_q + 1'b1;
  end

  // Timeout flag: marks the current burst as watchdog-closed until handshake.
  always_ff @(posedge clk) begin
    if (reset)          timeout_q <= 1'b0;
    else if (res_hs)    timeout_q <= 1'b0;
    else if (stall_hit) timeout_q <= 1'b1;
  end

  assign res_timeout = timeout_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign stall_hit      = 1'b0;
  assign res_timeout    = 1'b0;
`endif

  // Scheduler FSM with registered grant, pointer, readys and result valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
      rdy_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_q <= win;
            ptr_q   <= ~win;
            rdy_q   <= win ? 2'b10 : 2'b01;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if ((accept && sel_last) || stall_hit) begin
            rdy_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In-flight tracker: one bit per accepted word, aligned with max_finder stages.
  always_ff @(posedge clk) begin
    if (reset) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[PIPE_LAT-2:0], accept};
  end

  // Running maximum, folded only when a tracked word leaves the pipeline.
  always_ff @(posedge clk) begin
    if (reset)                                             acc_q <= '0;
    else if (res_hs)                                       acc_q <= '0;
    else if (vld_pipe_q[PIPE_LAT-1] && (pipe_max > acc_q)) acc_q <= pipe_max;
  end

  // Word counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)                      cnt_q <= '0;
    else if (res_hs)                cnt_q <= '0;
    else if (accept && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign req0_ready = rdy_q[0];
  assign req1_ready = rdy_q[1];
  assign res_valid  = res_valid_q;
  assign res_value  = acc_q;
  assign res_id     = grant_q;
  assign res_count  = cnt_q;

endmodule

// File: tb/tb_max_sched.sv
// tb_max_sched: table vectors, directed corner sequences and randomized
// traffic checked against a transaction-level model of max_sched.
module tb_max_sched;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_lanes, req1_lanes;
  logic        req0_last, req1_last;
  logic        res_valid, res_ready;
  logic [3:0]  res_value;
  logic        res_id;
  logic [7:0]  res_count;
  logic        res_timeout;

  max_sched #(.WIDTH(4), .CNT_W(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_lanes  (req0_lanes),
    .req0_last   (req0_last),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_lanes  (req1_lanes),
    .req1_last   (req1_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_value   (res_value),
    .res_id      (res_id),
    .res_count   (res_count),
    .res_timeout (res_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int nchk = 0;
  int lacc = 0;
  int rc   = 0;
  logic [15:0] wbuf [0:299];

  typedef struct {
    logic [15:0] lanes;
    logic        id;
    logic [3:0]  exp_max;
  } vec_t;
  vec_t vt [8];

  typedef struct {
    int mx;
    int id;
    int cnt;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [15:0] d, input logic l);
    if (id == 0) begin
      req0_valid = v; req0_lanes = d; req0_last = l;
    end else begin
      req1_valid = v; req1_lanes = d; req1_last = l;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 16'h0, 1'b0);
    set_req(1, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Stream wbuf[0..n-1] from one requester; lacc = cycle of the final accept.
  task automatic send_burst(input int id, input int n, input bit use_last);
    int   i;
    int   g;
    logic rdy;
    i = 0;
    g = 0;
    set_req(id, 1'b1, wbuf[0], use_last && n == 1);
    while (i < n && g < 2000) begin
      rdy = (id == 0) ? req0_ready : req1_ready;
      if (rdy) lacc = cyc;
      tick();
      g++;
      if (rdy) begin
        i++;
        if (i < n) set_req(id, 1'b1, wbuf[i], use_last && i == n - 1);
        else       set_req(id, 1'b0, 16'h0, 1'b0);
      end
    end
    check("burst_done", i, n);
  endtask

  // Valid already driven: wait for this requester's ready, take one word.
  task automatic serve(input int id);
    int g;
    g = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && g < 100) begin
      tick();
      g++;
    end
    check("serve_grant", (id == 0) ? req0_ready : req1_ready, 1);
    lacc = cyc;
    tick();
    set_req(id, 1'b0, 16'h0, 1'b0);
  endtask

  // Wait (bounded) for res_valid; rc = cycle it was first seen.
  task automatic wait_res();
    int g;
    g = 0;
    while (res_valid !== 1'b1 && g < 200) begin
      tick();
      g++;
    end
    rc = cyc;
    check("res_wait", res_valid, 1);
  endtask

  function automatic int lanemax(input logic [15:0] d);
    int m;
    m = 0;
    for (int i = 0; i < 4; i++)
      if (int'(d[i*4 +: 4]) > m) m = int'(d[i*4 +: 4]);
    return m;
  endfunction

  // Random-phase state
  int         rem [2];
  int         gap [2];
  logic [15:0] w [2];
  logic [1:0] v, l, pv, ro, prev_r, accb;
  logic       prev_rv, rr, hs;
  int         mptr, nres, cur_max, cur_cnt, last_acc, expw, pre;
  int         seen;
  logic [3:0] bp_val;

  initial begin
    reset = 1'b1;
    res_ready = 1'b0;
    set_req(0, 1'b1, 16'hFFFF, 1'b1);
    set_req(1, 1'b1, 16'hFFFF, 1'b1);

    // Reset state, with valids asserted to show readys stay low.
    tick();
    tick();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_res_valid",  res_valid, 0);
    check("rst_res_value",  res_value, 0);
    check("rst_res_id",     res_id, 0);
    check("rst_res_count",  res_count, 0);
    check("rst_res_timeout", res_timeout, 0);
    do_reset();

    // Single-word table: value, id, count and 4-cycle latency.
    vt[0] = '{16'h7193, 1'b0, 4'd9};
    vt[1] = '{16'h0000, 1'b1, 4'd0};
    vt[2] = '{16'hFFFF, 1'b0, 4'd15};
    vt[3] = '{16'hF321, 1'b1, 4'd15};
    vt[4] = '{16'h000E, 1'b0, 4'd14};
    vt[5] = '{16'h0A00, 1'b1, 4'd10};
    vt[6] = '{16'h7878, 1'b0, 4'd8};
    vt[7] = '{16'h5555, 1'b1, 4'd5};
    res_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      int c0;
      c0 = cyc;
      wbuf[0] = vt[t].lanes;
      send_burst(int'(vt[t].id), 1, 1'b1);
      wait_res();
      check("vec_latency", rc - c0, 4);
      check("vec_value",   res_value, vt[t].exp_max);
      check("vec_id",      res_id, vt[t].id);
      check("vec_count",   res_count, 1);
      check("vec_timeout", res_timeout, 0);
      tick();
    end

    // Three-word burst from req1: maxima 5, 12, 8.
    wbuf[0] = 16'h1532;
    wbuf[1] = 16'h0C47;
    wbuf[2] = 16'h8123;
    send_burst(1, 3, 1'b1);
    wait_res();
    check("b3_latency", rc - lacc, 3);
    check("b3_value",   res_value, 12);
    check("b3_id",      res_id, 1);
    check("b3_count",   res_count, 3);
    tick();

    // Contention after reset: req0 first, then req1, then req1 again.
    do_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 16'h0002, 1'b1);
    set_req(1, 1'b1, 16'h0003, 1'b1);
    tick();
    check("cont1_r0", req0_ready, 1);
    check("cont1_r1", req1_ready, 0);
    tick();
    set_req(0, 1'b1, 16'h0004, 1'b1);
    wait_res();
    check("cont1_value", res_value, 2);
    check("cont1_id",    res_id, 0);
    tick();
    check("cont2_idle", {req1_ready, req0_ready}, 0);
    tick();
    check("cont2_r1", req1_ready, 1);
    check("cont2_r0", req0_ready, 0);
    tick();
    set_req(1, 1'b0, 16'h0, 1'b0);
    wait_res();
    check("cont2_value", res_value, 3);
    check("cont2_id",    res_id, 1);
    tick();
    serve(0);
    wait_res();
    check("cont3_value", res_value, 4);
    check("cont3_id",    res_id, 0);
    tick();
    set_req(0, 1'b1, 16'h0005, 1'b1);
    set_req(1, 1'b1, 16'h0006, 1'b1);
    tick();
    check("cont4_r1", req1_ready, 1);
    check("cont4_r0", req0_ready, 0);
    serve(1);
    wait_res();
    check("cont4_value", res_value, 6);
    check("cont4_id",    res_id, 1);
    tick();
    serve(0);
    wait_res();
    check("cont5_value", res_value, 5);
    check("cont5_id",    res_id, 0);
    tick();

    // Back-pressure: result held 5 cycles with req0 waiting.
    res_ready = 1'b0;
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'h0900;
    send_burst(1, 2, 1'b1);
    set_req(0, 1'b1, 16'h00A0, 1'b1);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", res_valid, 1);
      check("bp_value", res_value, 9);
      check("bp_id",    res_id, 1);
      check("bp_count", res_count, 2);
      check("bp_readys", {req1_ready, req0_ready}, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_idle_readys", {req1_ready, req0_ready}, 0);
    check("bp_released", res_valid, 0);
    tick();
    check("bp_grant_r0", req0_ready, 1);
    serve(0);
    wait_res();
    bp_val = res_value;
    check("bp_next_value", bp_val, 10);
    check("bp_next_id",    res_id, 0);
    check("bp_next_count", res_count, 1);
    tick();

    // Mid-burst reset: discard two words, then a fresh burst must be clean.
    set_req(0, 1'b1, 16'h00F0, 1'b0);
    serve(0);
    set_req(0, 1'b1, 16'h0303, 1'b0);
    serve(0);
    reset = 1'b1;
    tick();
    check("mrst_req0_ready", req0_ready, 0);
    check("mrst_req1_ready", req1_ready, 0);
    check("mrst_res_valid",  res_valid, 0);
    check("mrst_res_value",  res_value, 0);
    check("mrst_res_id",     res_id, 0);
    check("mrst_res_count",  res_count, 0);
    check("mrst_res_timeout", res_timeout, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid === 1'b1) seen = 1;
      tick();
    end
    check("mrst_no_result", seen, 0);
    set_req(0, 1'b1, 16'h21B4, 1'b1);
    serve(0);
    wait_res();
    check("mrst_fresh_value", res_value, 11);
    check("mrst_fresh_count", res_count, 1);
    check("mrst_fresh_id",    res_id, 0);
    tick();

    // Counter saturation: 260 words report 255.
    for (int i = 0; i < 260; i++) wbuf[i] = {4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3)};
    send_burst(0, 260, 1'b1);
    wait_res();
    check("sat_count", res_count, 255);
    check("sat_value", res_value, 15);
    tick();

`ifdef MAX_SCHED_TIMEOUT_EN
    // Watchdog: one word (max 6), then owner idles.
    wbuf[0] = 16'h0610;
    send_burst(0, 1, 1'b0);
    wait_res();
    check("wd_value",   res_value, 6);
    check("wd_count",   res_count, 1);
    check("wd_timeout", res_timeout, 1);
    check("wd_id",      res_id, 0);
    tick();
`endif

    // Randomized traffic against the burst-level model.
    do_reset();
    v = '0; l = '0; pv = '0; prev_r = '0; prev_rv = 1'b0;
    w[0] = '0; w[1] = '0;
    rem[0] = 0; rem[1] = 0; gap[0] = 0; gap[1] = 0;
    mptr = 0; nres = 0; cur_max = 0; cur_cnt = 0; last_acc = -100;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      ro = {req1_ready, req0_ready};
      for (int r = 0; r < 2; r++) begin
        if (ro[r] && !prev_r[r]) begin
          expw = (pv[0] && pv[1]) ? mptr : (pv[1] ? 1 : 0);
          check("rnd_grant_who", r, expw);
          check("rnd_grant_req", pv[r], 1);
          mptr = 1 - r;
        end
      end
      check("rnd_excl", ro[0] & ro[1], 0);
      if (res_valid === 1'b1) begin
        if (!prev_rv) check("rnd_latency", cyc - last_acc, 3);
        check("rnd_ready_in_done", ro, 0);
        if (exp_q.size() == 0) begin
          check("rnd_spurious_result", 1, 0);
        end else begin
          check("rnd_value", res_value, exp_q[0].mx);
          check("rnd_id",    res_id, exp_q[0].id);
          check("rnd_count", res_count, exp_q[0].cnt);
          check("rnd_timeout", res_timeout, 0);
        end
      end
      prev_rv = res_valid;
      prev_r  = ro;
      for (int r = 0; r < 2; r++) begin
        if (!v[r]) begin
          if (gap[r] > 0) gap[r]--;
          else if ($urandom_range(0, 3) != 0) begin
            if (rem[r] == 0) rem[r] = $urandom_range(1, 5);
            v[r] = 1'b1;
            w[r] = 16'($urandom);
            l[r] = (rem[r] == 1);
          end
        end
      end
      set_req(0, v[0], w[0], l[0]);
      set_req(1, v[1], w[1], l[1]);
      rr = ($urandom_range(0, 9) < 7);
      res_ready = rr;
      hs   = (res_valid === 1'b1) && rr;
      accb = ro & v;
      pv   = v;
      pre  = cyc;
      tick();
      if (hs) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        nres++;
      end
      for (int r = 0; r < 2; r++) begin
        if (accb[r]) begin
          if (lanemax(w[r]) > cur_max) cur_max = lanemax(w[r]);
          cur_cnt++;
          if (l[r]) begin
            exp_q.push_back('{cur_max, r, cur_cnt});
            cur_max  = 0;
            cur_cnt  = 0;
            last_acc = pre;
          end
          rem[r]--;
          v[r]   = 1'b0;
          gap[r] = $urandom_range(0, 3);
        end
      end
    end
    check("rnd_enough_results", nres > 50, 1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/max_sched.md
# max_sched

Round-robin scheduler that shares one four-lane max-reduction pipeline between two requesters. Each requester streams a burst of packed 4-lane words ending in a `last` flag. The block owns the pipeline for the whole burst, feeds it, tracks its 2-cycle latency, folds per-word maxima into a running maximum, and returns one tagged result per burst over a valid/ready port. It sits between the lane producers and the consumers of per-burst peak values.

## Interface
- `WIDTH`, default 4: unsigned lane width in bits.
- `CNT_W`, default 8: width of the burst word counter.
- `TIMEOUT`, default 16: stall cycles before a burst is forcibly closed. Used only with `MAX_SCHED_TIMEOUT_EN`.
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req0_valid` / `req1_valid`, input, 1: requester word valid.
- `req0_ready` / `req1_ready`, output, 1: word accepted when ready and valid are both high at a rising edge.
- `req0_lanes` / `req1_lanes`, input, 4*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH].
- `req0_last` / `req1_last`, input, 1: marks the final word of the burst.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: consumer accepts the result.
- `res_value`, output, WIDTH: maximum over all lanes of all accepted words in the burst.
- `res_id`, output, 1: requester that owned the burst.
- `res_count`, output, CNT_W: words accepted in the burst; saturates at all-ones.
- `res_timeout`, output, 1: burst was closed by the watchdog, not by `last`.

## Operation
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
- **IDLE:**
  - If any valid is high, register the grant and go to ACTIVE.
  - If both are high, the priority pointer picks the winner. The pointer resets to 0.
  - The pointer moves to the other requester on each grant.
  - Both ready outputs are low in IDLE.
- **ACTIVE:**
  - The granted requester's ready is high; the other's is low.
  - Each accepted word drives the pipeline and increments the word counter.
  - Accepting a word with `last` set moves the FSM to DRAIN, and ready drops the next cycle.
- **DRAIN:** held until the 2-bit in-flight shift register is empty, then go to DONE.
- **DONE:**
  - `res_valid` is high; `res_value`, `res_id`, `res_count` and `res_timeout` are stable.
  - Handshake with `res_ready` high returns the FSM to IDLE. The accumulator, counter and timeout flag are cleared.
- **Accumulator:** an unsigned WIDTH register, cleared to 0 (neutral for unsigned max).
  - Updated with max(acc, pipeline output) only when the shift register's tail bit is set.
  - Pipeline output on non-tracked cycles is ignored.
- **Counter:** increments per accepted word, holds at 2^CNT_W-1.
- **Non-granted requester:** never sees ready while another burst is in ACTIVE, DRAIN or DONE.
- **Reset at any time:**
  - All state clears next cycle; the in-flight burst is discarded, with no partial result.
  - Pipeline registers also clear.

## Timing
- Reset values: `req0_ready`, `req1_ready`, `res_valid`, `res_value`, `res_id`, `res_count` and `res_timeout` are all 0.
- Word accepted in cycle k:
  - pipeline pair stage valid in cycle k+1;
  - pipeline max valid in cycle k+2;
  - accumulator updated at end of k+2.
- `last` accepted in cycle k: DRAIN in k+1..k+2, `res_valid` high from cycle k+3.
- Grant latency: valid first seen in IDLE in cycle 0 → ready high in cycle 1.
- Single-word burst: `res_valid` in cycle 4 at the earliest.
- Back-to-back bursts: after the result handshake in cycle d, the next grant decision is made in cycle d+1 (IDLE).
- Throughput in ACTIVE: one word per cycle.

## Configuration
- `MAX_SCHED_TIMEOUT_EN` defined:
  - In ACTIVE, a stall counter increments each cycle the granted requester's valid is low, and clears on an accepted word.
  - On reaching `TIMEOUT`, ready drops, the FSM enters DRAIN, and `res_timeout` is set for that result.
- `MAX_SCHED_TIMEOUT_EN` undefined:
  - No stall counter; a burst waits indefinitely for `last`.
  - `res_timeout` is tied to 0. The `TIMEOUT` parameter is unused.

## Structure
- Shared package `max_sched_pkg`:
  - FSM state enum;
  - `NUM_LANES` = 4;
  - `PIPE_LAT` = 2;
  - requester ID type.
- One sub-module: the existing four-lane max pipeline `max_finder`.
  - Instantiated once with parameter `WIDTH`.
  - Inputs driven from a mux selected by the registered grant.

## Test plan
- **Single word:** req0 sends one word, lanes 0..3 = 3,9,1,7, `last`=1, `res_ready`=1 → `res_valid` in cycle 4, `res_value`=9, `res_id`=0, `res_count`=1.
- **Three-word burst:** req1 sends words with maxima 5, 12, 8, last on the third → `res_value`=12, `res_id`=1, `res_count`=3, `res_valid` 3 cycles after the last accept.
- **Contention:** both valid in IDLE after reset → req0 served first, req1 second; the next contention picks req1.
- **Back-pressure:** `res_ready` low 5 cycles in DONE → outputs stable, both readys low, no new grant until the handshake.
- **Mid-burst reset:** reset asserted in ACTIVE after 2 words → all outputs 0 next cycle, no `res_valid` for that burst, fresh burst afterward is correct.
- **Watchdog:** with `MAX_SCHED_TIMEOUT_EN`, req0 sends one word (max 6) then idles 16 cycles → `res_valid` with `res_value`=6, `res_count`=1, `res_timeout`=1.
